vram_dma: RTL
=============

Name: vram_dma

Overview:
- Upstream feeder for the GPU VRAM write port.
- Copies a block of bytes from CPU-side synchronous memory into VRAM (tiles, sprites, palettes) and drives the `vram_data` / `vram_address` / `vram_we` interface.
- Writes are issued only while the timing generator's `writable` window is high, so the display is never corrupted.
- Sustains one byte per clock inside the window and stalls losslessly outside it.

Parameters:
- ADDR_W, 12: VRAM address width in bits; destination wraps modulo 2^ADDR_W.
- SRC_W, 16: source (CPU memory) address width; source wraps modulo 2^SRC_W.

Ports:
- clk  in  1  pixel clock (12.5875 MHz)
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle request to begin a transfer
- src_base  in  SRC_W  first source address, sampled on accepted start
- dst_base  in  ADDR_W  first VRAM address, sampled on accepted start
- length  in  ADDR_W+1  byte count, sampled on accepted start; 0 is allowed
- writable  in  1  VRAM write window from video timing
- mem_rd  out  1  source read strobe
- mem_addr  out  SRC_W  source read address
- mem_data  in  8  source read data, valid exactly 1 cycle after mem_rd
- vram_we  out  1  VRAM write strobe
- vram_address  out  ADDR_W  VRAM write address
- vram_data  out  8  VRAM write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, FIFO is emptied, in-flight read is discarded. This applies at the next edge even mid-transfer, and no done pulse is produced.
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN: start=1 with length!=0. Base addresses and length are latched; busy=1 from the next cycle.
  - IDLE -> FINISH: start=1 with length=0. No reads or writes occur.
  - RUN -> FINISH: all `length` bytes have been written.
  - FINISH -> IDLE: after one cycle. done=1 and busy=1 during FINISH; both are 0 the following cycle.
- start is ignored outside IDLE, including in the FINISH cycle.
- Datapath: one in-flight read register plus a 2-entry FIFO of {addr, data}.
- Read issue (combinational mem_rd; registered mem_addr counter):
  - Condition: state=RUN, writable=1, reads_remaining>0, and (fifo_count + inflight − drain) < 2.
  - On issue: src counter +1 (wrapping), reads_remaining −1.
- Capture: in the cycle after issue, mem_data is pushed into the FIFO with its destination address. dst counter +1, wrapping modulo 2^ADDR_W.
- Drain (combinational from FIFO head):
  - vram_we = fifo_nonempty & writable.
  - vram_address and vram_data always show the FIFO head.
  - On each vram_we cycle: pop, writes_remaining −1.
- Throughput: with writable held high, first vram_we occurs 2 cycles after the start edge's RUN entry, then one write per cycle.
  - Write addresses: dst_base, dst_base+1, …
  - Data: mem[src_base], mem[src_base+1], …, in order.
- writable falling mid-transfer:
  - New issues stop the same cycle.
  - An outstanding read still lands in the FIFO; the FIFO never overflows at 2 entries.
  - vram_we is 0 while writable=0.
  - Transfer resumes in order when writable returns, with no loss or duplication.
- Simultaneous push and pop on the same cycle are legal; fifo_count is unchanged.
- RUN -> FINISH transition: the cycle after the last pop.

Optional Feature:
- Macro: VRAM_DMA_FILL_EN.
- Defined:
  - Adds inputs `fill` (1 bit) and `fill_value` (8 bits), both sampled on accepted start.
  - When fill=1, mem_rd stays 0 and fill_value is pushed directly instead of mem_data.
  - Same writable gating, ordering and done timing; one byte per cycle.
- Undefined:
  - Ports are absent; copy mode only.

Test Plan:
- Basic copy: start, src_base=0x0100, dst_base=0x020, length=4, writable=1, mem[0x100..0x103]=AA,BB,CC,DD -> writes 020=AA, 021=BB, 022=CC, 023=DD on consecutive cycles; done 1 cycle after last write; busy 0 next cycle.
- Window stall: length=8, writable dropped for 5 cycles after the 3rd write -> vram_we=0 throughout the gap; all 8 bytes written in order, none duplicated; mem_rd=0 while writable=0.
- Zero length and busy lockout:
  - start with length=0 -> no mem_rd, no vram_we; done pulses the cycle after start.
  - Second start during RUN -> ignored; original transfer completes unchanged.
- Wrap-around: ADDR_W=12, dst_base=0xFFE, src_base=0xFFFF, length=4 -> VRAM addresses FFE, FFF, 000, 001; source addresses FFFF, 0000, 0001, 0002.
- Reset mid-transfer: rst for 1 cycle after 2 of 6 writes -> all outputs 0 next cycle, no done, no further writes; a new start then works normally.
- VRAM_DMA_FILL_EN: fill=1, fill_value=0x5A, dst_base=0x100, length=3 -> 100..102 all 5A; mem_rd never asserted.

Source files
------------

// File: rtl/vram_dma.sv
// vram_dma: copies a block of bytes from CPU-side synchronous memory into
// VRAM through a one-deep read pipeline and a 2-entry {addr, data} FIFO.
// VRAM writes happen only while the video timing "writable" window is high.
// Optional feature macro: VRAM_DMA_FILL_EN (adds fill / fill_value inputs
// for constant-fill transfers that never read source memory).
//
// Handshake note: there is no backpressure on either side. A source read is
// requested by mem_rd and its data is taken from mem_data exactly one cycle
// later; a VRAM write is a single-cycle vram_we strobe with address/data
// valid in that same cycle. start is honoured only in IDLE.
module vram_dma #(
    parameter int ADDR_W = 12,
    parameter int SRC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SRC_W-1:0]  src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   length,
    input  logic              writable,
`ifdef VRAM_DMA_FILL_EN
    input  logic              fill,
    input  logic [7:0]        fill_value,
`endif
    output logic              mem_rd,
    output logic [SRC_W-1:0]  mem_addr,
    input  logic [7:0]        mem_data,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_address,
    output logic [7:0]        vram_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SRC_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   reads_rem_q, reads_rem_d;
    logic [ADDR_W:0]   writes_rem_q, writes_rem_d;
    logic              inflight_q, inflight_d;

    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic [ADDR_W-1:0] fifo_addr_d [2];
    logic [7:0]        fifo_data_q [2];
    logic [7:0]        fifo_data_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              fill_mode;
    logic [7:0]        push_data;

`ifdef VRAM_DMA_FILL_EN
    logic              fill_q, fill_d;
    logic [7:0]        fill_val_q, fill_val_d;
    assign fill_mode = fill_q;
    assign push_data = fill_q ? fill_val_q : mem_data;
`else
    assign fill_mode = 1'b0;
    assign push_data = mem_data;
`endif

    logic       accept;
    logic       issue;
    logic       push;
    logic       pop;
    logic       last_pop;
    logic [2:0] occupancy;

    // Issue/drain decisions: occupancy counts FIFO entries plus the read in
    // flight, minus the entry leaving this cycle, so the FIFO never exceeds 2.
    always_comb begin
        accept    = (state_q == ST_IDLE) && start;
        pop       = (count_q != 2'd0) && writable;
        push      = inflight_q;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == ST_RUN) && writable &&
                    (reads_rem_q != '0) && (occupancy < 3'd2);
        last_pop  = pop && (writes_rem_q == (ADDR_W+1)'(1));
    end

    assign mem_rd       = issue && !fill_mode;
    assign mem_addr     = src_q;
    assign vram_we      = pop;
    assign vram_address = fifo_addr_q[rd_ptr_q];
    assign vram_data    = fifo_data_q[rd_ptr_q];
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign dbg_state    = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-length requests go straight to the done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                if (last_pop) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: counters, in-flight flag and FIFO bookkeeping.
    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        reads_rem_d  = reads_rem_q;
        writes_rem_d = writes_rem_q;
        inflight_d   = issue;
        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
`ifdef VRAM_DMA_FILL_EN
        fill_d       = fill_q;
        fill_val_d   = fill_val_q;
`endif
        if (accept) begin
            src_d        = src_base;
            dst_d        = dst_base;
            reads_rem_d  = length;
            writes_rem_d = length;
`ifdef VRAM_DMA_FILL_EN
            fill_d       = fill;
            fill_val_d   = fill_value;
`endif
        end else begin
            if (issue) begin
                src_d       = src_q + SRC_W'(1);
                reads_rem_d = reads_rem_q - (ADDR_W+1)'(1);
            end
            if (push) begin
                fifo_addr_d[wr_ptr_q] = dst_q;
                fifo_data_d[wr_ptr_q] = push_data;
                wr_ptr_d              = ~wr_ptr_q;
                dst_d                 = dst_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d     = ~rd_ptr_q;
                writes_rem_d = writes_rem_q - (ADDR_W+1)'(1);
            end
        end
    end

    // Datapath registers; reset empties the FIFO and drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q          <= '0;
            dst_q          <= '0;
            reads_rem_q    <= '0;
            writes_rem_q   <= '0;
            inflight_q     <= 1'b0;
            fifo_addr_q[0] <= '0;
            fifo_addr_q[1] <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= '0;
`ifdef VRAM_DMA_FILL_EN
            fill_q         <= 1'b0;
            fill_val_q     <= '0;
`endif
        end else begin
            src_q          <= src_d;
            dst_q          <= dst_d;
            reads_rem_q    <= reads_rem_d;
            writes_rem_q   <= writes_rem_d;
            inflight_q     <= inflight_d;
            fifo_addr_q[0] <= fifo_addr_d[0];
            fifo_addr_q[1] <= fifo_addr_d[1];
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
`ifdef VRAM_DMA_FILL_EN
            fill_q         <= fill_d;
            fill_val_q     <= fill_val_d;
`endif
        end
    end

endmodule
